control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single clock; all state changes occur on the rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port IRCU, input, 4 bits: opcode from the instruction register.
REQ-004 SHALL have port Start, input, 1 bit: request to execute the opcode on IRCU.
REQ-005 SHALL have port Aload, output, 1 bit: load strobe for datapath register A.
REQ-006 SHALL have port Bload, output, 1 bit: load strobe for datapath register B.
REQ-007 SHALL have port ANSload, output, 1 bit: load strobe for the answer register.
REQ-008 SHALL have port A_select, output, 1 bit: A operand source select.
REQ-009 SHALL have port B_select, output, 1 bit: B operand source select.
REQ-010 SHALL have port select_mode, output, 2 bits: ALU operation select.
REQ-011 SHALL have port Busy, output, 1 bit: high while an instruction is in progress.
REQ-012 SHALL have port Done, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port Halted, output, 1 bit: high after a HALT opcode.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, LOAD, EXEC, WRITE, DONE and HALT; all outputs SHALL be a function of the state register and the latched opcode only.
REQ-015 In IDLE with Start=1 and IRCU!=4'hF, the block SHALL latch IRCU into an internal opcode register and enter LOAD on the same edge.
REQ-016 In IDLE with Start=1 and IRCU=4'hF, the block SHALL enter HALT.
REQ-017 In IDLE with Start=0, the block SHALL remain in IDLE.
REQ-018 LOAD SHALL last 1 cycle with Aload=1 and Bload=1, then go to EXEC.
REQ-019 EXEC SHALL last 1 cycle with all load strobes 0, then go to WRITE.
REQ-020 WRITE SHALL last 1 cycle with ANSload=1, then go to DONE.
REQ-021 DONE SHALL last 1 cycle with Done=1, then go to IDLE.
REQ-022 In LOAD, EXEC and WRITE, select_mode SHALL equal op[1:0], A_select SHALL equal op[2] and B_select SHALL equal op[3]; in all other states these outputs SHALL be 0.
REQ-023 Busy SHALL be 1 in LOAD, EXEC, WRITE and DONE, and 0 in IDLE and HALT.
REQ-024 Latency: for Start sampled at edge k, Aload/Bload SHALL be high during cycle k+1, ANSload during cycle k+3, and Done during cycle k+4.
REQ-025 Start SHALL be ignored in every state except IDLE, including Start held high through DONE; the next instruction can start no earlier than the first IDLE cycle.
REQ-026 IRCU changes after the latch edge SHALL NOT affect an instruction in progress.
REQ-027 HALT SHALL drive Halted=1 with all strobes 0, and SHALL be exited only by Reset.
REQ-028 Done, Aload, Bload and ANSload SHALL never be high in the same cycle as each other, except Aload together with Bload.

Reset
REQ-029 Reset=0 SHALL immediately force state IDLE, opcode register 4'h0, and all outputs 0, independent of Clk.
REQ-030 Reset asserted mid-instruction SHALL abort the instruction with no further strobes; the first Start after release SHALL be handled normally.

Configuration
REQ-031 With macro CU_INSTR_COUNT_EN defined, the block SHALL add output Instr_count (8 bits); it resets to 0, increments by 1 on every entry to DONE, wraps from 255 to 0, and does not count HALT.
REQ-032 Without CU_INSTR_COUNT_EN, the Instr_count port and its register SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Reset low, then released; Start=1 with IRCU=4'h0 -> Aload=Bload=1 for 1 cycle, ANSload=1 two cycles later, Done=1 one cycle after that, select_mode=0 throughout.
REQ-034 IRCU=4'b1110 with Start -> select_mode=2'b10, A_select=1, B_select=1 during LOAD/EXEC/WRITE; IRCU changed to 4'h0 during EXEC -> outputs unchanged.
REQ-035 Start held high continuously with IRCU=4'h3 -> back-to-back instructions with exactly one IDLE cycle between a Done pulse and the next Aload.
REQ-036 IRCU=4'hF with Start -> Halted=1 and Busy=0; later Starts ignored; Reset low -> Halted=0, IDLE.
REQ-037 Reset pulsed low during WRITE -> ANSload drops immediately, no Done pulse; with CU_INSTR_COUNT_EN, Instr_count=0.
REQ-038 With CU_INSTR_COUNT_EN: 257 completed instructions -> Instr_count=1.

Source files
------------

// File: rtl/control_unit.sv
// Sequencer that steps each opcode through LOAD/EXEC/WRITE/DONE and parks in HALT on 4'hF.
// Optional CU_INSTR_COUNT_EN adds an 8-bit completed-instruction counter on Instr_count.
module control_unit (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] IRCU,
    input  logic       Start,
    output logic       Aload,
    output logic       Bload,
    output logic       ANSload,
    output logic       A_select,
    output logic       B_select,
    output logic [1:0] select_mode,
    output logic       Busy,
    output logic       Done,
    output logic       Halted
`ifdef CU_INSTR_COUNT_EN
    ,
    output logic [7:0] Instr_count
`endif
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned SEL_W = 2;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_HALT  = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;

    logic              aload_q, aload_d;
    logic              bload_q, bload_d;
    logic              ansload_q, ansload_d;
    logic              a_sel_q, a_sel_d;
    logic              b_sel_q, b_sel_d;
    logic [SEL_W-1:0]  mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              halted_q, halted_d;

    // State and latched opcode
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next state, opcode latch, and Moore output decode of the upcoming state
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        aload_d   = 1'b0;
        bload_d   = 1'b0;
        ansload_d = 1'b0;
        a_sel_d   = 1'b0;
        b_sel_d   = 1'b0;
        mode_d    = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        halted_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (IRCU == OP_HALT) begin
                        state_d = S_HALT;
                    end else begin
                        op_d    = IRCU;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_LOAD: begin
                aload_d = 1'b1;
                bload_d = 1'b1;
                busy_d  = 1'b1;
            end
            S_EXEC: begin
                busy_d = 1'b1;
            end
            S_WRITE: begin
                ansload_d = 1'b1;
                busy_d    = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b1;
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase

        // Operand and ALU selects follow the latched opcode only while datapath is active
        if ((state_d == S_LOAD) || (state_d == S_EXEC) || (state_d == S_WRITE)) begin
            mode_d  = op_d[SEL_W-1:0];
            a_sel_d = op_d[2];
            b_sel_d = op_d[3];
        end
    end

    // Registered outputs; reset clears them without waiting for a clock edge
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            aload_q   <= 1'b0;
            bload_q   <= 1'b0;
            ansload_q <= 1'b0;
            a_sel_q   <= 1'b0;
            b_sel_q   <= 1'b0;
            mode_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            aload_q   <= aload_d;
            bload_q   <= bload_d;
            ansload_q <= ansload_d;
            a_sel_q   <= a_sel_d;
            b_sel_q   <= b_sel_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            halted_q  <= halted_d;
        end
    end

    assign Aload       = aload_q;
    assign Bload       = bload_q;
    assign ANSload     = ansload_q;
    assign A_select    = a_sel_q;
    assign B_select    = b_sel_q;
    assign select_mode = mode_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Halted      = halted_q;

`ifdef CU_INSTR_COUNT_EN
    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count entries into DONE; HALT never reaches DONE so it is not counted
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Instr_count = cnt_q;
`endif

endmodule
